// File: rtl/output_bcd_unit_if.sv
// Result/strobe bundle between the processor OUT path and the BCD display unit.
interface output_bcd_unit_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  out;
  logic [WIDTH-1:0]      dado;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  modport master (output out, dado, input busy, done, neg, bcd, seg);
  modport slave  (input out, dado, output busy, done, neg, bcd, seg);
endinterface

// File: rtl/output_bcd_unit.sv
// Captures the OUT word on each strobe rise and converts it to BCD and 7-segment
// patterns with a one-shift-per-clock double-dabble engine and a one-deep request buffer.
module output_bcd_unit #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter bit SIGNED = 1'b1,
  parameter bit BLANK  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  output_bcd_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0: r = 7'h40;
      4'd1: r = 7'h79;
      4'd2: r = 7'h24;
      4'd3: r = 7'h30;
      4'd4: r = 7'h19;
      4'd5: r = 7'h12;
      4'd6: r = 7'h02;
      4'd7: r = 7'h78;
      4'd8: r = 7'h00;
      4'd9: r = 7'h10;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  // Walk from the top digit down; once a non-zero digit (or digit 0) is seen, everything below is lit.
  function automatic logic [7*DIGITS-1:0] seg_word(input logic [AW-1:0] v);
    logic [7*DIGITS-1:0] r;
    logic lit;
    r   = '0;
    lit = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((v[4*i +: 4] != 4'd0) || (i == 0) || !BLANK) lit = 1'b1;
      r[7*i +: 7] = lit ? seg7(v[4*i +: 4]) : 7'h7F;
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RST = seg_word('0);

  state_t              state;
  logic                out_q;
  logic                pending;
  logic [WIDTH-1:0]    pend_word;
  logic [WIDTH-1:0]    mag;
  logic [AW-1:0]       acc;
  logic                sign_q;
  logic [CW-1:0]       cnt;

  logic                rise;
  logic [WIDTH-1:0]    load_word;
  logic [WIDTH-1:0]    load_mag;
  logic [AW-1:0]       adj;
  logic [AW+WIDTH-1:0] shifted;
  logic [AW-1:0]       acc_next;
  logic [WIDTH-1:0]    mag_next;

  // A fresh rise in IDLE wins over the buffered word; the magnitude is taken modulo 2^WIDTH so the most negative value stays exact.
  always_comb begin
    rise      = bus.out & ~out_q;
    load_word = rise ? bus.dado : pend_word;
    load_mag  = (SIGNED && load_word[WIDTH-1]) ? (-load_word) : load_word;
    adj       = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted  = {adj, mag} << 1;
    acc_next = shifted[AW+WIDTH-1:WIDTH];
    mag_next = shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_q     <= 1'b1;
      pending   <= 1'b0;
      pend_word <= '0;
      mag       <= '0;
      acc       <= '0;
      sign_q    <= 1'b0;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.neg   <= 1'b0;
      bus.bcd   <= '0;
      bus.seg   <= SEG_RST;
    end else begin
      out_q    <= bus.out;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise || pending) begin
            mag      <= load_mag;
            sign_q   <= SIGNED && load_word[WIDTH-1];
            acc      <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            pend_word <= bus.dado;
            pending   <= 1'b1;
          end
          acc <= acc_next;
          mag <= mag_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.bcd  <= acc_next;
            bus.seg  <= seg_word(acc_next);
            bus.neg  <= sign_q;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
